// File: rtl/cifra_pkg.sv
// Shared definitions for the block cipher and decipher datapaths:
// block geometry, FSM state type, the byte-matrix transpose and the
// round-key schedule (key rotated left by one byte per round index).
package cifra_pkg;

    localparam int BLOCO_BYTES   = 16;
    localparam int LARGURA_BLOCO = 128;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        RODADA = 2'd1,
        PRONTO = 2'd2
    } estado_t;

    // Byte k sits at bits 127-8k; matrix element (lin,col) is byte 4*lin+col.
    // Transpose: out[4*i+j] = in[4*j+i].
    function automatic logic [LARGURA_BLOCO-1:0] transpoe(input logic [LARGURA_BLOCO-1:0] bloco);
        logic [LARGURA_BLOCO-1:0] res;
        res = '0;
        for (int k = 0; k < BLOCO_BYTES; k++) begin
            res[LARGURA_BLOCO-1-8*k -: 8] = bloco[LARGURA_BLOCO-1-8*(4*(k%4)+(k/4)) -: 8];
        end
        return res;
    endfunction

    // Round key r: chave rotated left by 8*r bits, wrapping mod 128.
    function automatic logic [LARGURA_BLOCO-1:0] chave_rodada(input logic [LARGURA_BLOCO-1:0] chave,
                                                              input logic [3:0] r);
        logic [2*LARGURA_BLOCO-1:0] dobro;
        dobro = {chave, chave} << {r, 3'b000};
        return dobro[2*LARGURA_BLOCO-1:LARGURA_BLOCO];
    endfunction

endpackage

// File: rtl/transpoe_rodada.sv
// One decipher round, purely combinational: XOR the round key for
// index r into the state, then undo the byte-matrix transposition.
module transpoe_rodada
    import cifra_pkg::*;
(
    input  logic [127:0] s,
    input  logic [127:0] chave,
    input  logic [3:0]   r,
    output logic [127:0] proximo
);

    // Round function: transpose(s XOR rk(r)).
    always_comb begin
        proximo = transpoe(s ^ chave_rodada(chave, r));
    end

endmodule

// File: rtl/decifra_bloco.sv
// Iterative 128-bit block decipher, one round per clock.
// Rounds run from RODADAS-1 down to 0 over a latched block and key.
// Optional build macro DECIFRA_CONTADOR_EN adds a saturating 16-bit
// count of delivered blocks on port blocos_decifrados.
//
// Handshake: a transfer happens on a rising edge where valid and ready
// are both high. The producer holds valid and data stable until that
// edge; ready may depend on state only, never on the partner's valid.
module decifra_bloco #(
    parameter int RODADAS       = 2,
    parameter int LARGURA_BLOCO = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     entrada_valida,
    output logic                     entrada_pronta,
    input  logic [LARGURA_BLOCO-1:0] bloco_cifrado,
    input  logic [LARGURA_BLOCO-1:0] chave,
    output logic                     saida_valida,
    input  logic                     saida_pronta,
    output logic [LARGURA_BLOCO-1:0] bloco_decifrado,
`ifdef DECIFRA_CONTADOR_EN
    output logic [15:0]              blocos_decifrados,
`endif
    output cifra_pkg::estado_t       estado
);

    import cifra_pkg::*;

    localparam logic [3:0] CONTADOR_INICIAL = 4'(RODADAS - 1);

    estado_t                  estado_prox;
    logic [LARGURA_BLOCO-1:0] s;
    logic [LARGURA_BLOCO-1:0] k;
    logic [3:0]               contador;
    logic [LARGURA_BLOCO-1:0] proximo;

    transpoe_rodada u_rodada (
        .s       (s),
        .chave   (k),
        .r       (contador),
        .proximo (proximo)
    );

    // State, working block, latched key and round counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado   <= OCIOSO;
            s        <= '0;
            k        <= '0;
            contador <= '0;
        end else begin
            estado <= estado_prox;
            case (estado)
                OCIOSO: begin
                    if (entrada_valida) begin
                        s        <= bloco_cifrado;
                        k        <= chave;
                        contador <= CONTADOR_INICIAL;
                    end
                end
                RODADA: begin
                    s <= proximo;
                    // Counter parks at 0 on the last round instead of wrapping.
                    if (contador != 4'd0) begin
                        contador <= contador - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next state and handshake outputs; no new input is taken while busy.
    always_comb begin
        estado_prox    = estado;
        entrada_pronta = 1'b0;
        saida_valida   = 1'b0;
        case (estado)
            OCIOSO: begin
                entrada_pronta = 1'b1;
                if (entrada_valida) begin
                    estado_prox = RODADA;
                end
            end
            RODADA: begin
                if (contador == 4'd0) begin
                    estado_prox = PRONTO;
                end
            end
            PRONTO: begin
                saida_valida = 1'b1;
                if (saida_pronta) begin
                    estado_prox = OCIOSO;
                end
            end
            default: begin
                estado_prox = OCIOSO;
            end
        endcase
    end

    assign bloco_decifrado = s;

`ifdef DECIFRA_CONTADOR_EN
    logic [15:0] contagem;

    // Saturating count of completed output handshakes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            contagem <= '0;
        end else if (estado == PRONTO && saida_pronta && contagem != 16'hFFFF) begin
            contagem <= contagem + 16'd1;
        end
    end

    assign blocos_decifrados = contagem;
`endif

endmodule

// File: tb/tb_decifra_bloco.sv
// Directed bench for decifra_bloco: unit 0 built with RODADAS=1,
// unit 1 with RODADAS=2; both share clock and reset.
module tb_decifra_bloco;

  import cifra_pkg::*;

  logic          clk;
  logic          rst;
  logic          entrada_valida  [2];
  logic          entrada_pronta  [2];
  logic [127:0]  bloco_cifrado   [2];
  logic [127:0]  chave           [2];
  logic          saida_valida    [2];
  logic          saida_pronta    [2];
  logic [127:0]  bloco_decifrado [2];
  estado_t       estado          [2];
`ifdef DECIFRA_CONTADOR_EN
  logic [15:0]   contagem        [2];
`endif

  logic [127:0] exp_q[$];
  int n_ok;
  int n_total;

  decifra_bloco #(.RODADAS(1)) dut0 (
    .clk             (clk),
    .rst             (rst),
    .entrada_valida  (entrada_valida[0]),
    .entrada_pronta  (entrada_pronta[0]),
    .bloco_cifrado   (bloco_cifrado[0]),
    .chave           (chave[0]),
    .saida_valida    (saida_valida[0]),
    .saida_pronta    (saida_pronta[0]),
    .bloco_decifrado (bloco_decifrado[0]),
`ifdef DECIFRA_CONTADOR_EN
    .blocos_decifrados (contagem[0]),
`endif
    .estado          (estado[0])
  );

  decifra_bloco #(.RODADAS(2)) dut1 (
    .clk             (clk),
    .rst             (rst),
    .entrada_valida  (entrada_valida[1]),
    .entrada_pronta  (entrada_pronta[1]),
    .bloco_cifrado   (bloco_cifrado[1]),
    .chave           (chave[1]),
    .saida_valida    (saida_valida[1]),
    .saida_pronta    (saida_pronta[1]),
    .bloco_decifrado (bloco_decifrado[1]),
`ifdef DECIFRA_CONTADOR_EN
    .blocos_decifrados (contagem[1]),
`endif
    .estado          (estado[1])
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic verifica(input string tag, input logic [127:0] obs, input logic [127:0] esp);
    n_total++;
    if (obs === esp) begin
      n_ok++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, esp);
    end
  endtask

  function automatic logic [127:0] aleatorio();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offer one block; returns at the negedge right after the accept edge.
  // Inputs are scrambled afterwards: they must no longer matter.
  task automatic envia(input int u, input logic [127:0] b, input logic [127:0] k,
                       input logic [127:0] esperado);
    @(negedge clk);
    verifica("entrada_pronta antes", 128'(entrada_pronta[u]), 128'd1);
    bloco_cifrado[u]  = b;
    chave[u]          = k;
    entrada_valida[u] = 1'b1;
    exp_q.push_back(esperado);
    @(negedge clk);
    entrada_valida[u] = 1'b0;
    bloco_cifrado[u]  = aleatorio();
    chave[u]          = aleatorio();
  endtask

  // Wait (bounded) for saida_valida; n counts edges after the accept edge.
  task automatic espera_valida(input int u, output int n);
    n = 0;
    while (!saida_valida[u] && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic recebe(input int u, input int lat);
    int n;
    logic [127:0] esp;
    espera_valida(u, n);
    verifica("latencia", 128'(n), 128'(lat));
    esp = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
    verifica("bloco_decifrado", bloco_decifrado[u], esp);
    saida_pronta[u] = 1'b1;
    @(negedge clk);
    saida_pronta[u] = 1'b0;
    verifica("volta ocioso", 128'(entrada_pronta[u]), 128'd1);
    verifica("saida_valida baixa", 128'(saida_valida[u]), 128'd0);
  endtask

  initial begin
    int n;
    logic [127:0] retido;
    logic estavel;
    logic bloqueado;
    logic [127:0] esp;

    n_ok    = 0;
    n_total = 0;
    rst     = 1'b1;
    for (int u = 0; u < 2; u++) begin
      entrada_valida[u] = 1'b0;
      bloco_cifrado[u]  = '0;
      chave[u]          = '0;
      saida_pronta[u]   = 1'b0;
    end

    // Reset values
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      verifica("reset entrada_pronta", 128'(entrada_pronta[u]), 128'd1);
      verifica("reset saida_valida", 128'(saida_valida[u]), 128'd0);
      verifica("reset bloco", bloco_decifrado[u], 128'd0);
      verifica("reset estado", 128'(estado[u]), 128'(OCIOSO));
    end
    rst = 1'b0;

    // Pure transpose, one round
    envia(0, 128'h50564543415253494c41544641544552, 128'd0,
          128'h50414c41565241544553544543494652);
    recebe(0, 1);

    // Key XOR then transpose, one round
    envia(0, 128'd0, 128'h000102030405060708090a0b0c0d0e0f,
          128'h0004080c0105090d02060a0e03070b0f);
    recebe(0, 1);

    // saida_pronta held high in advance has no effect before PRONTO
    saida_pronta[0] = 1'b1;
    envia(0, 128'h00112233445566778899aabbccddeeff, 128'd0,
          128'h004488cc115599dd2266aaee3377bbff);
    verifica("pronta antecipada estado", 128'(estado[0]), 128'(RODADA));
    recebe(0, 1);

    // Two rounds with zero key: double transpose is identity
    envia(1, 128'hDEADBEEF0123456789ABCDEFCAFEF00D, 128'd0,
          128'hDEADBEEF0123456789ABCDEFCAFEF00D);
    recebe(1, 2);

    // Two rounds, nonzero key: result is rotl8(key) XOR transpose(key)
    envia(1, 128'd0, 128'h000102030405060708090a0b0c0d0e0f,
          128'h01060b0804030e050b0c01020e09040f);
    recebe(1, 2);

    // Backpressure: hold output 10 cycles, offer a competing input meanwhile
    envia(1, 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, 128'd0,
          128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0);
    espera_valida(1, n);
    verifica("bp latencia", 128'(n), 128'd2);
    retido            = bloco_decifrado[1];
    entrada_valida[1] = 1'b1;
    bloco_cifrado[1]  = 128'h11111111222222223333333344444444;
    estavel   = 1'b1;
    bloqueado = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bloco_decifrado[1] !== retido || saida_valida[1] !== 1'b1) estavel = 1'b0;
      if (entrada_pronta[1] !== 1'b0) bloqueado = 1'b0;
    end
    verifica("bp saida estavel", 128'(estavel), 128'd1);
    verifica("bp entrada bloqueada", 128'(bloqueado), 128'd1);
    entrada_valida[1] = 1'b0;
    saida_pronta[1]   = 1'b1;
    @(negedge clk);
    saida_pronta[1] = 1'b0;
    verifica("bp volta ocioso", 128'(estado[1]), 128'(OCIOSO));
    verifica("bp saida_valida", 128'(saida_valida[1]), 128'd0);
    esp = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
    verifica("bp bloco", retido, esp);

    // Reset in the middle of a round aborts immediately
    envia(1, 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5, 128'h0123456789ABCDEF0123456789ABCDEF,
          128'd0);
    void'(exp_q.pop_back());
    verifica("meio estado", 128'(estado[1]), 128'(RODADA));
    rst = 1'b1;
    #1;
    verifica("abort saida_valida", 128'(saida_valida[1]), 128'd0);
    verifica("abort entrada_pronta", 128'(entrada_pronta[1]), 128'd1);
    verifica("abort bloco", bloco_decifrado[1], 128'd0);
    @(negedge clk);
    rst = 1'b0;
    envia(1, 128'd0, 128'h000102030405060708090a0b0c0d0e0f,
          128'h01060b0804030e050b0c01020e09040f);
    recebe(1, 2);

`ifdef DECIFRA_CONTADOR_EN
    // Three back-to-back blocks counted since the last reset
    for (int i = 0; i < 3; i++) begin
      envia(0, 128'h50564543415253494c41544641544552, 128'd0,
            128'h50414c41565241544553544543494652);
      recebe(0, 1);
    end
    verifica("contador 3", 128'(contagem[0]), 128'd3);
    rst = 1'b1;
    #1;
    verifica("contador reset", 128'(contagem[0]), 128'd0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_ok, n_total);
    $finish;
  end

endmodule
